// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer slave: register offsets, bit positions
// and the APB tracking state encoding.
package apb_timer_pkg;

   localparam logic [7:0] CTRL_OFS   = 8'h00;
   localparam logic [7:0] LOAD_OFS   = 8'h04;
   localparam logic [7:0] COUNT_OFS  = 8'h08;
   localparam logic [7:0] STATUS_OFS = 8'h0C;
   localparam logic [7:0] PRESC_OFS  = 8'h10;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_AR   = 1;
   localparam int CTRL_IE   = 2;
   localparam int STAT_EXP  = 0;
   localparam int STAT_PERR = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_st_t;

endpackage

// File: rtl/apb_slave_if.sv
// APB setup/access tracker: captures the setup-phase address and direction,
// issues one commit strobe per legal transfer and flags sequencing violations.
module apb_slave_if
   import apb_timer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       sel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   output logic       wr_stb,
   output logic       rd_stb,
   output logic [7:0] addr_q,
   output logic       prot_err_pulse
);

   apb_st_t state, next_state;
   logic    write_q;
   logic    capture;
   logic    match;

   assign match = (paddr == addr_q) && (pwrite == write_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
      end else begin
         state <= next_state;
         if (capture) begin
            addr_q  <= paddr;
            write_q <= pwrite;
         end
      end
   end

   always_comb begin
      next_state     = state;
      capture        = 1'b0;
      wr_stb         = 1'b0;
      rd_stb         = 1'b0;
      prot_err_pulse = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sel && !penable) begin
               next_state = ST_SETUP;
               capture    = 1'b1;
            end else if (sel && penable) begin
               prot_err_pulse = 1'b1;
            end
         end
         ST_SETUP: begin
            // The access phase must repeat the setup-phase address and direction
            if (sel && penable && match) begin
               next_state = ST_ACCESS;
               wr_stb     = write_q;
               rd_stb     = !write_q;
            end else begin
               next_state     = ST_IDLE;
               prot_err_pulse = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (!sel) begin
               next_state = ST_IDLE;
            end else if (!penable) begin
               next_state = ST_SETUP;
               capture    = 1'b1;
            end else begin
               next_state     = ST_IDLE;
               prot_err_pulse = 1'b1;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/apb_timer_slave.sv
// APB down-counting timer with prescaler, auto-reload, sticky expiry/protocol
// flags and a level interrupt; register file and timer core live here.
module apb_timer_slave
   import apb_timer_pkg::*;
#(
   parameter int SEL_IDX = 0,
   parameter int CNT_W   = 32
)
(
   input  logic        Hclk,
   input  logic        Hreset,
   input  logic [2:0]  Pselx,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        irq
);

   logic             wr_stb, rd_stb, prot_err_pulse;
   logic [7:0]       addr_q;
   logic [2:0]       ctrl;
   logic [CNT_W-1:0] load, count;
   logic [7:0]       presc, presc_cnt;
   logic             expired, prot_err;
   logic             tick, expire;
   logic             wr_ctrl, wr_load, wr_stat, wr_presc;
   logic [31:0]      rd_data;
   logic             unused_bits;

   assign unused_bits = &{1'b0, Pselx, Paddr[31:8]};

   apb_slave_if u_if (
      .clk            (Hclk),
      .rst            (Hreset),
      .sel            (Pselx[SEL_IDX]),
      .penable        (Penable),
      .pwrite         (Pwrite),
      .paddr          (Paddr[7:0]),
      .wr_stb         (wr_stb),
      .rd_stb         (rd_stb),
      .addr_q         (addr_q),
      .prot_err_pulse (prot_err_pulse)
   );

   assign wr_ctrl  = wr_stb && (addr_q == CTRL_OFS);
   assign wr_load  = wr_stb && (addr_q == LOAD_OFS);
   assign wr_stat  = wr_stb && (addr_q == STATUS_OFS);
   assign wr_presc = wr_stb && (addr_q == PRESC_OFS);

   assign tick   = ctrl[CTRL_EN] && (presc_cnt == presc);
   assign expire = tick && (count == '0);
   assign irq    = expired & ctrl[CTRL_IE];

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         ctrl      <= '0;
         load      <= '0;
         count     <= '0;
         presc     <= '0;
         presc_cnt <= '0;
         expired   <= 1'b0;
         prot_err  <= 1'b0;
         Prdata    <= '0;
      end else begin
         // A CTRL write overrides the one-shot self-disable on the same edge
         if (wr_ctrl)
            ctrl <= Pwdata[2:0];
         else if (expire && !ctrl[CTRL_AR])
            ctrl[CTRL_EN] <= 1'b0;

         if (wr_presc)
            presc <= Pwdata[7:0];

         if (wr_load) begin
            load      <= Pwdata[CNT_W-1:0];
            count     <= Pwdata[CNT_W-1:0];
            presc_cnt <= '0;
         end else begin
            if (ctrl[CTRL_EN])
               presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
            if (tick) begin
               if (count != '0)
                  count <= count - CNT_W'(1);
               else if (ctrl[CTRL_AR])
                  count <= load;
            end
         end

         // Sticky flags: a new set beats a simultaneous write-1-to-clear
         expired  <= expire | (expired & ~(wr_stat & Pwdata[STAT_EXP]));
         prot_err <= prot_err_pulse | (prot_err & ~(wr_stat & Pwdata[STAT_PERR]));

         Prdata <= rd_stb ? rd_data : '0;
      end
   end

   always_comb begin
      rd_data = '0;
      case (addr_q)
         CTRL_OFS:   rd_data[2:0] = ctrl;
         LOAD_OFS:   rd_data[CNT_W-1:0] = load;
         COUNT_OFS:  rd_data[CNT_W-1:0] = count;
         STATUS_OFS: begin
            rd_data[STAT_EXP]  = expired;
            rd_data[STAT_PERR] = prot_err;
         end
         PRESC_OFS:  rd_data[7:0] = presc;
         default:    rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: the driver queues expected read data,
// a bus monitor pops and compares whenever a read response appears.
module tb_apb_timer_slave;
   import apb_timer_pkg::*;

   localparam logic [2:0] SEL = 3'b010;

   logic        Hclk = 1'b0;
   logic        Hreset;
   logic [2:0]  Pselx;
   logic        Penable, Pwrite;
   logic [31:0] Paddr, Pwdata, Prdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] exp;
      string       nm;
   } rd_exp_t;

   rd_exp_t sb[$];

   apb_timer_slave #(.SEL_IDX(1), .CNT_W(32)) dut (
      .Hclk    (Hclk),
      .Hreset  (Hreset),
      .Pselx   (Pselx),
      .Penable (Penable),
      .Pwrite  (Pwrite),
      .Paddr   (Paddr),
      .Pwdata  (Pwdata),
      .Prdata  (Prdata),
      .irq     (irq)
   );

   always #5 Hclk = ~Hclk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic setup(input logic [7:0] a, input logic w, input logic [31:0] d);
      Pselx = SEL; Penable = 1'b0; Paddr = {24'h0, a}; Pwrite = w; Pwdata = d;
      @(posedge Hclk); #1;
   endtask

   task automatic access();
      Penable = 1'b1;
      @(posedge Hclk); #1;
   endtask

   task automatic idle();
      Pselx = 3'b000; Penable = 1'b0;
      @(posedge Hclk); #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      setup(a, 1'b1, d); access(); idle();
   endtask

   task automatic rd_setup(input logic [7:0] a, input logic [31:0] exp, input string nm);
      rd_exp_t e;
      e.exp = exp; e.nm = nm;
      sb.push_back(e);
      setup(a, 1'b0, 32'h0);
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
      rd_setup(a, exp, nm); access(); idle();
   endtask

   task automatic check_irq(input logic exp, input string nm);
      @(negedge Hclk);
      check(nm, {31'h0, irq}, {31'h0, exp});
   endtask

   // Read-response monitor
   initial begin
      forever begin
         @(posedge Hclk);
         if (!Hreset && Pselx[1] && Penable && !Pwrite) begin
            @(negedge Hclk);
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read: prdata %h with nothing expected", Prdata);
            end else begin
               rd_exp_t e;
               e = sb.pop_front();
               check(e.nm, Prdata, e.exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1);
   end

   initial begin
      Hreset = 1'b1; Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
      Paddr = '0; Pwdata = '0;
      repeat (3) @(posedge Hclk);
      #1 Hreset = 1'b0;
      @(negedge Hclk);
      check("reset_prdata", Prdata, 32'h0);
      check("reset_irq", {31'h0, irq}, 32'h0);
      @(posedge Hclk); #1;

      // Reset values
      rd(CTRL_OFS,   32'h0, "rst_ctrl");
      rd(LOAD_OFS,   32'h0, "rst_load");
      rd(COUNT_OFS,  32'h0, "rst_count");
      rd(STATUS_OFS, 32'h0, "rst_status");
      rd(PRESC_OFS,  32'h0, "rst_presc");
      rd(8'h20,      32'h0, "rst_unmapped");

      // One-shot countdown, prescale 0
      wr(LOAD_OFS, 32'd3);
      wr(PRESC_OFS, 32'd0);
      rd(COUNT_OFS, 32'd3, "os_count3");
      setup(CTRL_OFS, 1'b1, 32'h5); access();
      rd_setup(COUNT_OFS, 32'd2, "os_count2"); access();
      rd_setup(COUNT_OFS, 32'd0, "os_count0"); access();
      idle();
      rd(CTRL_OFS,   32'h4, "os_ctrl_en_cleared");
      rd(STATUS_OFS, 32'h1, "os_expired");
      check_irq(1'b1, "os_irq");

      wr(LOAD_OFS, 32'd3);
      setup(CTRL_OFS, 1'b1, 32'h5); access();
      idle();
      rd_setup(COUNT_OFS, 32'd1, "os_count1"); access();
      idle();
      rd(COUNT_OFS, 32'd0, "os_count_hold0");
      wr(STATUS_OFS, 32'h1);
      check_irq(1'b0, "w1c_irq_low");

      // Auto-reload, prescale 1
      wr(LOAD_OFS, 32'd2);
      wr(PRESC_OFS, 32'd1);
      setup(CTRL_OFS, 1'b1, 32'h3); access();
      rd_setup(COUNT_OFS, 32'd2, "ar_count2");  access();
      rd_setup(COUNT_OFS, 32'd1, "ar_count1");  access();
      rd_setup(COUNT_OFS, 32'd0, "ar_count0");  access();
      rd_setup(COUNT_OFS, 32'd2, "ar_reload2"); access();
      idle();
      rd(CTRL_OFS,   32'h3, "ar_en_kept");
      rd(STATUS_OFS, 32'h1, "ar_expired");
      check_irq(1'b0, "ar_irq_masked");
      wr(CTRL_OFS, 32'h2);
      wr(STATUS_OFS, 32'h1);
      rd(STATUS_OFS, 32'h0, "ar_w1c_clear");

      // Address change between setup and access
      setup(LOAD_OFS, 1'b1, 32'd9);
      Penable = 1'b1; Paddr = {24'h0, COUNT_OFS};
      @(posedge Hclk); #1;
      idle();
      rd(STATUS_OFS, 32'h2, "perr_set");
      rd(LOAD_OFS,   32'd2, "perr_no_write");
      wr(STATUS_OFS, 32'h2);
      rd(STATUS_OFS, 32'h0, "perr_w1c");

      // Back-to-back transfers
      setup(PRESC_OFS, 1'b1, 32'h5A); access();
      rd_setup(STATUS_OFS, 32'h0, "b2b_no_perr"); access();
      idle();
      rd(PRESC_OFS,  32'h5A, "b2b_presc");
      rd(STATUS_OFS, 32'h0,  "b2b_status");

      // LOAD write coincides with a tick
      wr(PRESC_OFS, 32'd1);
      wr(LOAD_OFS, 32'd5);
      setup(CTRL_OFS, 1'b1, 32'h3); access();
      setup(LOAD_OFS, 1'b1, 32'd7); access();
      rd_setup(COUNT_OFS, 32'd7, "load_beats_tick"); access();
      idle();
      wr(CTRL_OFS, 32'h0);

      // W1C of EXPIRED coincides with a one-shot expiry
      wr(STATUS_OFS, 32'h3);
      wr(PRESC_OFS, 32'd0);
      wr(LOAD_OFS, 32'd1);
      setup(CTRL_OFS, 1'b1, 32'h1); access();
      setup(STATUS_OFS, 1'b1, 32'h1); access();
      idle();
      rd(STATUS_OFS, 32'h1, "set_beats_w1c");
      rd(CTRL_OFS,   32'h0, "oneshot_en_off");
      rd(COUNT_OFS,  32'h0, "oneshot_count0");

      // Reset during the access phase of a CTRL write
      setup(CTRL_OFS, 1'b1, 32'h7);
      Penable = 1'b1;
      #2 Hreset = 1'b1;
      @(posedge Hclk); #1;
      Hreset = 1'b0; Pselx = 3'b000; Penable = 1'b0;
      @(posedge Hclk); #1;
      rd(CTRL_OFS,   32'h0, "rst_abort_ctrl");
      rd(STATUS_OFS, 32'h0, "rst_abort_status");
      rd(LOAD_OFS,   32'h0, "rst_abort_load");
      check_irq(1'b0, "rst_abort_irq");

      repeat (4) @(posedge Hclk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d reads outstanding, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
